// File: rtl/rob_commit_buffer_if.sv
// Bundles the dispatch, CDB, rename read and commit signals of the reorder buffer.
// The master side is whoever drives dispatch/CDB/read tags; the buffer is the slave.
interface rob_commit_buffer_if #(
   parameter int WIDTH   = 31,
   parameter int ROB     = 2,
   parameter int CONTROL = 6,
   parameter int REG     = 4
);
   logic               dispatchValid;
   logic [REG:0]       dispatchDest;
   logic               dispatchIsControl;
   logic               robFull;
   logic [ROB:0]       allocTag;

   logic               cdbValid;
   logic [ROB:0]       cdbRobEntry;
   logic [WIDTH:0]     cdbResult;
   logic               cdbIsControl;
   logic [WIDTH:0]     cdbTarget;
   logic [CONTROL:0]   cdbPcControl;

   logic [ROB:0]       readTagA;
   logic [ROB:0]       readTagB;
   logic               readReadyA;
   logic               readReadyB;
   logic [WIDTH:0]     readValueA;
   logic [WIDTH:0]     readValueB;

   logic               commitValid;
   logic [ROB:0]       commitTag;
   logic [REG:0]       commitDest;
   logic [WIDTH:0]     commitResult;
   logic               commitIsControl;
   logic [WIDTH:0]     commitTarget;
   logic               flush;

   modport master (
      output dispatchValid, dispatchDest, dispatchIsControl,
      output cdbValid, cdbRobEntry, cdbResult, cdbIsControl, cdbTarget, cdbPcControl,
      output readTagA, readTagB,
      input  robFull, allocTag,
      input  readReadyA, readReadyB, readValueA, readValueB,
      input  commitValid, commitTag, commitDest, commitResult, commitIsControl, commitTarget,
      input  flush
   );

   modport slave (
      input  dispatchValid, dispatchDest, dispatchIsControl,
      input  cdbValid, cdbRobEntry, cdbResult, cdbIsControl, cdbTarget, cdbPcControl,
      input  readTagA, readTagB,
      output robFull, allocTag,
      output readReadyA, readReadyB, readValueA, readValueB,
      output commitValid, commitTag, commitDest, commitResult, commitIsControl, commitTarget,
      output flush
   );
endinterface

// File: rtl/rob_commit_buffer.sv
// Circular reorder buffer: in-order dispatch, CDB writeback, in-order single retirement,
// and a one-cycle flush that empties the buffer after a mispredicted branch retires.
//
// state    | meaning
// ST_RUN   | normal dispatch / writeback / commit
// ST_FLUSH | mispredict retired last cycle; flush high, buffer emptied at end of cycle
module rob_commit_buffer #(
   parameter int WIDTH   = 31,
   parameter int ROB     = 2,
   parameter int CONTROL = 6,
   parameter int REG     = 4
) (
   input  logic               clk,
   input  logic               reset,
   rob_commit_buffer_if.slave bus
);
   localparam int DEPTH = 1 << (ROB + 1);
   localparam logic [ROB+1:0] FULL_COUNT = (ROB + 2)'(DEPTH);
   localparam logic [ROB+1:0] ONE_COUNT  = (ROB + 2)'(1);
   localparam logic [ROB:0]   ONE_PTR    = (ROB + 1)'(1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_flush;
   logic [ROB:0]     r_head;
   logic [ROB:0]     r_tail;
   logic [ROB+1:0]   r_count;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] r_ready;
   logic [DEPTH-1:0] r_is_ctrl;
   logic [REG:0]     r_dest    [DEPTH];
   logic [WIDTH:0]   r_result  [DEPTH];
   logic [WIDTH:0]   r_target  [DEPTH];
   logic [CONTROL:0] r_pc_ctrl [DEPTH];

   logic w_full;
   logic w_flush_pending;
   logic w_dispatch;
   logic w_cdb_write;
   logic w_commit;
   logic w_mispredict;
   logic w_pc_ctrl_unused;

   assign w_full          = (r_count == FULL_COUNT);
   assign w_flush_pending = (r_state == ST_FLUSH);
   assign w_dispatch      = bus.dispatchValid && !w_full && !w_flush_pending;
   assign w_cdb_write     = bus.cdbValid && r_busy[bus.cdbRobEntry] && !w_flush_pending;
   assign w_commit        = r_busy[r_head] && r_ready[r_head] && !w_flush_pending;
   assign w_mispredict    = w_commit && r_is_ctrl[r_head] && r_pc_ctrl[r_head][0];

   // Only the redirect flag steers retirement; the rest of pcControl is held alongside it.
   assign w_pc_ctrl_unused = ^r_pc_ctrl[r_head][CONTROL:1];

   assign bus.robFull  = w_full;
   assign bus.allocTag = r_tail;
   assign bus.flush    = r_flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_flush <= 1'b0;
         r_busy  <= '0;
         r_ready <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_FLUSH: begin
               r_state <= ST_RUN;
               r_flush <= 1'b0;
               r_busy  <= '0;
               r_ready <= '0;
               r_head  <= '0;
               r_tail  <= '0;
               r_count <= '0;
            end
            default: begin
               if (w_dispatch) begin
                  r_busy[r_tail]    <= 1'b1;
                  r_ready[r_tail]   <= 1'b0;
                  r_dest[r_tail]    <= bus.dispatchDest;
                  r_is_ctrl[r_tail] <= bus.dispatchIsControl;
                  r_tail            <= r_tail + ONE_PTR;
               end
               if (w_cdb_write) begin
                  r_ready[bus.cdbRobEntry]  <= 1'b1;
                  r_result[bus.cdbRobEntry] <= bus.cdbResult;
                  if (bus.cdbIsControl) begin
                     r_target[bus.cdbRobEntry]  <= bus.cdbTarget;
                     r_pc_ctrl[bus.cdbRobEntry] <= bus.cdbPcControl;
                  end
               end
               if (w_commit) begin
                  r_busy[r_head] <= 1'b0;
                  r_head         <= r_head + ONE_PTR;
               end
               if (w_dispatch && !w_commit) begin
                  r_count <= r_count + ONE_COUNT;
               end else if (!w_dispatch && w_commit) begin
                  r_count <= r_count - ONE_COUNT;
               end
               if (w_mispredict) begin
                  r_state <= ST_FLUSH;
                  r_flush <= 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      bus.commitValid     = w_commit;
      bus.commitTag       = '0;
      bus.commitDest      = '0;
      bus.commitResult    = '0;
      bus.commitIsControl = 1'b0;
      bus.commitTarget    = '0;
      if (w_commit) begin
         bus.commitTag       = r_head;
         bus.commitDest      = r_dest[r_head];
         bus.commitResult    = r_result[r_head];
         bus.commitIsControl = r_is_ctrl[r_head];
         bus.commitTarget    = r_target[r_head];
      end
   end

   // Same-cycle CDB bypass so rename never misses a value landing this cycle.
   always_comb begin
      bus.readReadyA = r_ready[bus.readTagA];
      bus.readValueA = r_result[bus.readTagA];
      if (bus.cdbValid && (bus.cdbRobEntry == bus.readTagA) && r_busy[bus.readTagA]) begin
         bus.readReadyA = 1'b1;
         bus.readValueA = bus.cdbResult;
      end
   end

   always_comb begin
      bus.readReadyB = r_ready[bus.readTagB];
      bus.readValueB = r_result[bus.readTagB];
      if (bus.cdbValid && (bus.cdbRobEntry == bus.readTagB) && r_busy[bus.readTagB]) begin
         bus.readReadyB = 1'b1;
         bus.readValueB = bus.cdbResult;
      end
   end
endmodule

// File: tb/tb_rob_commit_buffer.sv
// Scoreboard bench for rob_commit_buffer: expected retirements are queued at dispatch
// and popped by a negedge monitor whenever the buffer reports a commit.
module tb_rob_commit_buffer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rob_commit_buffer_if bus ();
   rob_commit_buffer dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [2:0]  tag;
      logic [4:0]  dest;
      logic        ctrl;
      logic [31:0] result;
      logic [31:0] target;
      logic [6:0]  pcc;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       pend [8];
   exp_t       mon_e;
   int         n_err = 0;
   int         n_checks = 0;
   int         cyc = 0;
   logic [2:0] m_tail = '0;
   int         m_count = 0;
   bit         m_flushing = 1'b0;
   int         commit_cyc [8];
   int         tc0, tc2;
   logic [2:0] t, prev_t;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.dispatchValid = 1'b0;
      bus.cdbValid      = 1'b0;
   endtask

   task automatic dispatch(input logic [4:0] dest, input logic ctrl, input logic [6:0] pcc,
                           input logic [31:0] res, output logic [2:0] tag);
      exp_t e;
      bus.dispatchValid     = 1'b1;
      bus.dispatchDest      = dest;
      bus.dispatchIsControl = ctrl;
      tag = m_tail;
      if (m_count < 8 && !m_flushing) begin
         chk("allocTag", bus.allocTag, m_tail);
         e.tag    = m_tail;
         e.dest   = dest;
         e.ctrl   = ctrl;
         e.result = res;
         e.target = ctrl ? $urandom : 32'h0;
         e.pcc    = pcc;
         pend[m_tail] = e;
         exp_q.push_back(e);
         m_tail  = m_tail + 3'd1;
         m_count = m_count + 1;
      end else if (!m_flushing) begin
         chk("robFull_on_drop", bus.robFull, 1);
      end
   endtask

   task automatic cdb(input logic [2:0] tag);
      bus.cdbValid     = 1'b1;
      bus.cdbRobEntry  = tag;
      bus.cdbResult    = pend[tag].result;
      bus.cdbIsControl = pend[tag].ctrl;
      bus.cdbTarget    = pend[tag].target;
      bus.cdbPcControl = pend[tag].pcc;
   endtask

   task automatic clear_model();
      exp_q.delete();
      m_count    = 0;
      m_tail     = '0;
      m_flushing = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      chk("rst_commitValid", bus.commitValid, 0);
      chk("rst_robFull", bus.robFull, 0);
      chk("rst_allocTag", bus.allocTag, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_readReadyA", bus.readReadyA, 0);
      tick();
   endtask

   task automatic wait_empty(input int maxc);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
      chk("drain_pending", exp_q.size(), 0);
   endtask

   // Commit monitor: compares every retirement against the oldest queued dispatch.
   always @(negedge clk) begin
      if (!reset) begin
         chk("flush", bus.flush, m_flushing);
         if (m_flushing) begin
            m_flushing = 1'b0;
            m_count    = 0;
            m_tail     = '0;
         end
         if (bus.commitValid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_commit", bus.commitValid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("commitTag", bus.commitTag, mon_e.tag);
               chk("commitDest", bus.commitDest, mon_e.dest);
               chk("commitResult", bus.commitResult, mon_e.result);
               chk("commitIsControl", bus.commitIsControl, mon_e.ctrl);
               if (mon_e.ctrl) chk("commitTarget", bus.commitTarget, mon_e.target);
               commit_cyc[mon_e.tag] = cyc;
               m_count = m_count - 1;
               if (mon_e.ctrl && mon_e.pcc[0]) begin
                  exp_q.delete();
                  m_flushing = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.dispatchValid = 1'b0; bus.dispatchDest = '0; bus.dispatchIsControl = 1'b0;
      bus.cdbValid = 1'b0; bus.cdbRobEntry = '0; bus.cdbResult = '0;
      bus.cdbIsControl = 1'b0; bus.cdbTarget = '0; bus.cdbPcControl = '0;
      bus.readTagA = '0; bus.readTagB = '0;
      for (int i = 0; i < 8; i++) commit_cyc[i] = -1;

      // Out-of-order completion, in-order retirement
      do_reset();
      for (int k = 0; k < 3; k++) begin
         dispatch(5'(k + 1), 1'b0, 7'h0, $urandom, t);
         tick();
      end
      cdb(3'd1); tick();
      tc0 = cyc; cdb(3'd0); tick();
      tick();
      tc2 = cyc; cdb(3'd2); tick();
      wait_empty(10);
      chk("commit_cyc0", commit_cyc[0], tc0 + 1);
      chk("commit_cyc1", commit_cyc[1], tc0 + 2);
      chk("commit_cyc2", commit_cyc[2], tc2 + 1);

      // Full buffer, dropped dispatch, tag reuse
      do_reset();
      for (int k = 0; k < 8; k++) begin
         dispatch(5'(k + 8), 1'b0, 7'h0, $urandom, t);
         tick();
      end
      @(negedge clk);
      chk("full_after_8", bus.robFull, 1);
      dispatch(5'd30, 1'b0, 7'h0, $urandom, t);
      tick();
      chk("alloc_after_drop", bus.allocTag, 0);
      cdb(3'd0); tick();
      dispatch(5'd29, 1'b0, 7'h0, $urandom, t);
      tick();
      dispatch(5'd28, 1'b0, 7'h0, $urandom, t);
      tick();
      @(negedge clk);
      chk("full_after_reuse", bus.robFull, 1);
      chk("alloc_after_reuse", bus.allocTag, 1);
      for (int k = 1; k <= 8; k++) begin
         cdb(3'(k));
         tick();
      end
      wait_empty(12);

      // Steady state, one dispatch and one commit per cycle across pointer wrap
      for (int i = 0; i < 22; i++) begin
         dispatch(5'(i), 1'b0, 7'h0, $urandom, t);
         if (i > 0) cdb(prev_t);
         prev_t = t;
         @(negedge clk);
         if (i >= 2) chk("steady_commit", bus.commitValid, 1);
         tick();
      end
      cdb(prev_t); tick();
      wait_empty(10);

      // Read ports: CDB bypass, storage, ignored write to idle tag
      do_reset();
      for (int k = 0; k < 4; k++) begin
         dispatch(5'(k + 2), 1'b0, 7'h0, (k == 3) ? 32'hDEADBEEF : $urandom, t);
         tick();
      end
      bus.readTagA = 3'd3; bus.readTagB = 3'd2;
      cdb(3'd3);
      @(negedge clk);
      chk("bypass_readyA", bus.readReadyA, 1);
      chk("bypass_valueA", bus.readValueA, 32'hDEADBEEF);
      chk("notready_B", bus.readReadyB, 0);
      tick();
      bus.readTagB = 3'd5;
      bus.cdbValid = 1'b1; bus.cdbRobEntry = 3'd5; bus.cdbResult = 32'h12345678;
      bus.cdbIsControl = 1'b0;
      @(negedge clk);
      chk("stored_readyA", bus.readReadyA, 1);
      chk("stored_valueA", bus.readValueA, 32'hDEADBEEF);
      chk("idle_bypass_B", bus.readReadyB, 0);
      tick();
      @(negedge clk);
      chk("idle_write_B", bus.readReadyB, 0);
      chk("idle_write_alloc", bus.allocTag, 4);
      tick();
      dispatch(5'd6, 1'b0, 7'h0, $urandom, t);
      tick();

      // Reset with five in flight and a CDB write in the same cycle
      reset = 1'b1;
      bus.readTagA = 3'd0; bus.readTagB = 3'd3;
      cdb(3'd0);
      tick();
      reset = 1'b0;
      clear_model();
      @(negedge clk);
      chk("inflight_rst_commitValid", bus.commitValid, 0);
      chk("inflight_rst_robFull", bus.robFull, 0);
      chk("inflight_rst_allocTag", bus.allocTag, 0);
      chk("inflight_rst_readyA", bus.readReadyA, 0);
      chk("inflight_rst_readyB", bus.readReadyB, 0);
      tick();

      // Mispredict on tag 1: younger ready entries squashed, flush pulse, empty buffer
      dispatch(5'd11, 1'b0, 7'h00, $urandom, t); tick();
      dispatch(5'd12, 1'b1, 7'h01, $urandom, t); tick();
      dispatch(5'd13, 1'b0, 7'h00, $urandom, t); tick();
      dispatch(5'd14, 1'b1, 7'h00, $urandom, t); tick();
      cdb(3'd2); tick();
      cdb(3'd3); tick();
      cdb(3'd0); tick();
      cdb(3'd1); tick();
      dispatch(5'd20, 1'b0, 7'h0, $urandom, t); tick();
      dispatch(5'd21, 1'b0, 7'h0, $urandom, t); tick();
      chk("alloc_after_flush", bus.allocTag, 0);
      chk("full_after_flush", bus.robFull, 0);
      chk("no_commit_after_flush", bus.commitValid, 0);
      dispatch(5'd22, 1'b0, 7'h0, $urandom, t); tick();
      cdb(t); tick();
      wait_empty(10);
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
